// File: rtl/uart_edge_monitor.sv
// uart_edge_monitor
// Synchronises and deglitches an asynchronous serial RX line, loops the
// filtered level back to TX, shifts the new level into a capture register on
// every qualifying edge and keeps a saturating count of those edges.

module uart_edge_monitor #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int FILT_CYC    = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_rx,
    input  logic [1:0]        i_edge_mode,
    input  logic              i_set_all,
    input  logic              i_clear_cnt,
    output logic              o_tx,
    output logic [DATA_W-1:0] o_capture,
    output logic [CNT_W-1:0]  o_edge_cnt,
    output logic              o_cnt_sat,
    output logic              o_edge_pulse
);

    // Filter count value at which a differing level is accepted on the next cycle
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic                   filt_level_q;
    logic [FILT_W-1:0]      filt_cnt_q;
    logic                   accept;
    logic                   qualify;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign o_tx       = filt_level_q;

    // Synchroniser chain: shifts every cycle, idles high like the line itself
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    // Edge acceptance and direction qualification, both evaluated in the accepting cycle
    always_comb begin
        accept  = i_enable && (sync_level != filt_level_q) && (filt_cnt_q == FILT_LAST);
        qualify = accept && ((sync_level && i_edge_mode[0]) || (!sync_level && i_edge_mode[1]));
    end

    // Deglitch filter: a new level must persist for FILT_CYC enabled cycles before it is taken
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            filt_level_q <= 1'b1;
            filt_cnt_q   <= '0;
        end else if (i_enable) begin
            if (sync_level == filt_level_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_level_q <= sync_level;
                filt_cnt_q   <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // Capture register: a qualifying edge shift outranks the all-ones preset
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            o_capture <= '0;
        end else if (qualify) begin
            o_capture <= {o_capture[DATA_W-2:0], sync_level};
        end else if (i_enable && i_set_all) begin
            o_capture <= '1;
        end
    end

    // Saturating edge counter with sticky flag; a clear outranks a coincident edge
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            o_edge_cnt <= '0;
            o_cnt_sat  <= 1'b0;
        end else if (i_enable && i_clear_cnt) begin
            o_edge_cnt <= '0;
            o_cnt_sat  <= 1'b0;
        end else if (qualify && (o_edge_cnt != CNT_MAX)) begin
            o_edge_cnt <= o_edge_cnt + CNT_W'(1);
            if (o_edge_cnt == (CNT_MAX - CNT_W'(1))) begin
                o_cnt_sat <= 1'b1;
            end
        end
    end

    // One-cycle strobe aligned with the filtered-level update
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            o_edge_pulse <= 1'b0;
        end else begin
            o_edge_pulse <= qualify;
        end
    end

endmodule

// File: tb/tb_uart_edge_monitor.sv
// tb_uart_edge_monitor
// Directed bench for uart_edge_monitor: a default-width instance plus a
// CNT_W=3 instance sharing the same inputs so counter saturation is reachable.

module tb_uart_edge_monitor;

    logic        clock;
    logic        i_reset;
    logic        i_enable;
    logic        i_rx;
    logic [1:0]  i_edge_mode;
    logic        i_set_all;
    logic        i_clear_cnt;

    logic        tx;
    logic [7:0]  capture;
    logic [15:0] edge_cnt;
    logic        cnt_sat;
    logic        edge_pulse;

    logic        small_tx;
    logic [7:0]  small_capture;
    logic [2:0]  small_cnt;
    logic        small_sat;
    logic        small_pulse;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        logic        rx;
        logic [1:0]  mode;
        logic        set_all;
        logic        clear;
        int          cycles;
        logic        exp_tx;
        logic [7:0]  exp_cap;
        logic [15:0] exp_cnt;
        logic [2:0]  exp_small_cnt;
        logic        exp_small_sat;
    } vec_t;

    vec_t vecs[$];

    uart_edge_monitor dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_rx         (i_rx),
        .i_edge_mode  (i_edge_mode),
        .i_set_all    (i_set_all),
        .i_clear_cnt  (i_clear_cnt),
        .o_tx         (tx),
        .o_capture    (capture),
        .o_edge_cnt   (edge_cnt),
        .o_cnt_sat    (cnt_sat),
        .o_edge_pulse (edge_pulse)
    );

    uart_edge_monitor #(.CNT_W(3)) dut_small (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_rx         (i_rx),
        .i_edge_mode  (i_edge_mode),
        .i_set_all    (i_set_all),
        .i_clear_cnt  (i_clear_cnt),
        .o_tx         (small_tx),
        .o_capture    (small_capture),
        .o_edge_cnt   (small_cnt),
        .o_cnt_sat    (small_sat),
        .o_edge_pulse (small_pulse)
    );

    // Free-running 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rx, input logic [1:0] mode, input logic en,
                                 input logic set_all, input logic clear);
        i_rx        = rx;
        i_edge_mode = mode;
        i_enable    = en;
        i_set_all   = set_all;
        i_clear_cnt = clear;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input logic etx, input logic [7:0] ecap,
                            input logic [15:0] ecnt, input logic epulse,
                            input logic [2:0] escnt, input logic essat);
        checkOutput({name, "_tx"},          32'(tx),            32'(etx));
        checkOutput({name, "_capture"},     32'(capture),       32'(ecap));
        checkOutput({name, "_cnt"},         32'(edge_cnt),      32'(ecnt));
        checkOutput({name, "_sat"},         32'(cnt_sat),       32'(1'b0));
        checkOutput({name, "_pulse"},       32'(edge_pulse),    32'(epulse));
        checkOutput({name, "_small_tx"},    32'(small_tx),      32'(etx));
        checkOutput({name, "_small_cap"},   32'(small_capture), 32'(ecap));
        checkOutput({name, "_small_cnt"},   32'(small_cnt),     32'(escnt));
        checkOutput({name, "_small_sat"},   32'(small_sat),     32'(essat));
        checkOutput({name, "_small_pulse"}, 32'(small_pulse),   32'(epulse));
    endtask

    task automatic addVec(input string name, input logic rx, input logic [1:0] mode,
                          input logic set_all, input logic clear, input int cycles,
                          input logic etx, input logic [7:0] ecap, input logic [15:0] ecnt,
                          input logic [2:0] escnt, input logic essat);
        vec_t v;
        v.name          = name;
        v.rx            = rx;
        v.mode          = mode;
        v.set_all       = set_all;
        v.clear         = clear;
        v.cycles        = cycles;
        v.exp_tx        = etx;
        v.exp_cap       = ecap;
        v.exp_cnt       = ecnt;
        v.exp_small_cnt = escnt;
        v.exp_small_sat = essat;
        vecs.push_back(v);
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i].rx, vecs[i].mode, 1'b1, vecs[i].set_all, vecs[i].clear);
            waitCycles(vecs[i].cycles);
            checkAll(vecs[i].name, vecs[i].exp_tx, vecs[i].exp_cap, vecs[i].exp_cnt, 1'b0,
                     vecs[i].exp_small_cnt, vecs[i].exp_small_sat);
        end
    endtask

    // Main directed sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Steady-state vectors: inputs held for 'cycles', then every output compared
        addVec("m01_low",   1'b0, 2'b01, 1'b0, 1'b0, 10, 1'b0, 8'h00, 16'd0, 3'd0, 1'b0);
        addVec("m01_high1", 1'b1, 2'b01, 1'b0, 1'b0, 10, 1'b1, 8'h01, 16'd1, 3'd1, 1'b0);
        addVec("m01_low2",  1'b0, 2'b01, 1'b0, 1'b0, 10, 1'b0, 8'h01, 16'd1, 3'd1, 1'b0);
        addVec("m01_high2", 1'b1, 2'b01, 1'b0, 1'b0, 10, 1'b1, 8'h03, 16'd2, 3'd2, 1'b0);
        addVec("set_all",   1'b1, 2'b01, 1'b1, 1'b0, 1,  1'b1, 8'hFF, 16'd2, 3'd2, 1'b0);
        addVec("clear_cnt", 1'b0, 2'b11, 1'b0, 1'b1, 1,  1'b0, 8'hFE, 16'd0, 3'd0, 1'b0);
        addVec("edge1",     1'b1, 2'b11, 1'b0, 1'b0, 8,  1'b1, 8'hFD, 16'd1, 3'd1, 1'b0);
        addVec("edge2",     1'b0, 2'b11, 1'b0, 1'b0, 8,  1'b0, 8'hFA, 16'd2, 3'd2, 1'b0);
        addVec("edge3",     1'b1, 2'b11, 1'b0, 1'b0, 8,  1'b1, 8'hF5, 16'd3, 3'd3, 1'b0);
        addVec("edge4",     1'b0, 2'b11, 1'b0, 1'b0, 8,  1'b0, 8'hEA, 16'd4, 3'd4, 1'b0);
        addVec("edge5",     1'b1, 2'b11, 1'b0, 1'b0, 8,  1'b1, 8'hD5, 16'd5, 3'd5, 1'b0);
        addVec("edge6",     1'b0, 2'b11, 1'b0, 1'b0, 8,  1'b0, 8'hAA, 16'd6, 3'd6, 1'b0);
        addVec("edge7",     1'b1, 2'b11, 1'b0, 1'b0, 8,  1'b1, 8'h55, 16'd7, 3'd7, 1'b1);
        addVec("edge8",     1'b0, 2'b11, 1'b0, 1'b0, 8,  1'b0, 8'hAA, 16'd8, 3'd7, 1'b1);
        addVec("edge9",     1'b1, 2'b11, 1'b0, 1'b0, 8,  1'b1, 8'h55, 16'd9, 3'd7, 1'b1);
        addVec("m00_high",  1'b1, 2'b00, 1'b0, 1'b0, 10, 1'b1, 8'h00, 16'd1, 3'd1, 1'b0);
        addVec("m00_low",   1'b0, 2'b00, 1'b0, 1'b0, 10, 1'b0, 8'h00, 16'd1, 3'd1, 1'b0);

        // Reset state
        i_reset = 1'b0;
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkAll("reset", 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0);
        i_reset = 1'b1;
        waitCycles(2);
        checkAll("idle", 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0);

        // Falling edge latency: pulse on the sixth posedge after driving the line
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        checkAll("lat_before", 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0);
        waitCycles(1);
        checkAll("lat_edge", 1'b0, 8'h00, 16'd1, 1'b1, 3'd1, 1'b0);
        waitCycles(1);
        checkOutput("lat_pulse_drop", 32'(edge_pulse), 32'(1'b0));

        // Three-cycle glitch is rejected, four-cycle pulse gives a rise and a fall
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(12);
        checkAll("glitch3", 1'b0, 8'h00, 16'd1, 1'b0, 3'd1, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(15);
        checkAll("pulse4", 1'b0, 8'h02, 16'd3, 1'b0, 3'd3, 1'b0);

        // Rising-only mode from a fresh reset with the line low
        i_reset = 1'b0;
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkAll("reset2", 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0);
        i_reset = 1'b1;
        runVectors(0, 4);

        // Preset coinciding with a falling edge: shift wins
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkAll("setall_edge", 1'b0, 8'hFE, 16'd3, 1'b1, 3'd3, 1'b0);

        // Clear, then nine edges to saturate the narrow counter
        runVectors(5, 14);

        // Clear coinciding with an edge: clear wins, capture still shifts
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
        waitCycles(1);
        checkAll("clear_edge", 1'b0, 8'hAA, 16'd0, 1'b1, 3'd0, 1'b0);

        // Disable mid-filter with preset and clear requested: everything holds
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, 1'b1);
        waitCycles(20);
        checkAll("disabled", 1'b0, 8'hAA, 16'd0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        checkAll("reenable1", 1'b0, 8'hAA, 16'd0, 1'b0, 3'd0, 1'b0);
        waitCycles(1);
        checkAll("reenable2", 1'b1, 8'h55, 16'd1, 1'b1, 3'd1, 1'b0);

        // Reset mid-filter: full latency restarts after release
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
        waitCycles(4);
        i_reset = 1'b0;
        waitCycles(1);
        checkAll("reset_mid", 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0);
        i_reset = 1'b1;
        waitCycles(5);
        checkAll("post_reset_wait", 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0);
        waitCycles(1);
        checkAll("post_reset_edge", 1'b0, 8'h00, 16'd1, 1'b1, 3'd1, 1'b0);

        // Mode 00: line tracked, nothing counted
        runVectors(15, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
